// File: rtl/procyon_fifo_reader.sv
// Read-side adapter from a synchronous FIFO to a ready/valid stream through a small skid buffer.
// Optional stall counter is enabled by defining PROCYON_FIFO_READER_PERF_EN.
module procyon_fifo_reader #(
  parameter int unsigned OPTN_DATA_WIDTH = 8,
  parameter int unsigned OPTN_SKID_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_flush,
  output logic                       o_fifo_ack,
  input  logic [OPTN_DATA_WIDTH-1:0] i_fifo_data,
  input  logic                       i_fifo_valid,
  output logic [OPTN_DATA_WIDTH-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready
`ifdef PROCYON_FIFO_READER_PERF_EN
  ,
  output logic [15:0]                o_stall_count
`endif
);

  localparam int unsigned PTR_W = (OPTN_SKID_DEPTH > 1) ? $clog2(OPTN_SKID_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OPTN_SKID_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [CNT_W-1:0]           count;
  logic [PTR_W-1:0]           head;
  logic [PTR_W-1:0]           tail;
  logic                       inflight;
  logic [OPTN_DATA_WIDTH-1:0] mem [OPTN_SKID_DEPTH];

  logic                       pop;
  logic                       capture;
  logic [OCC_W-1:0]           occupancy;

  assign pop       = o_valid & i_ready;
  assign capture   = inflight & ~i_flush;
  // Words already committed to the buffer once this cycle's pop is taken out.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

  // Reset gates the ack directly so it drops the moment n_rst falls.
  assign o_fifo_ack = n_rst & i_fifo_valid & ~i_flush
                    & (occupancy < OCC_W'(OPTN_SKID_DEPTH));

  assign o_valid = (count != '0);
  assign o_data  = mem[head];

  // Control state: occupancy, pointers and the one outstanding read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else if (i_flush) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_fifo_ack;
      count    <= count + CNT_W'(capture) - CNT_W'(pop);
      if (capture) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
    end
  end

  // Data storage carries no reset; contents are only observed behind o_valid.
  always_ff @(posedge clk) begin
    if (capture) mem[tail] <= i_fifo_data;
  end

`ifdef PROCYON_FIFO_READER_PERF_EN
  // Saturating count of cycles where downstream holds off valid data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_stall_count <= '0;
    end else if (i_flush) begin
      o_stall_count <= '0;
    end else if (o_valid && !i_ready && (o_stall_count != 16'hFFFF)) begin
      o_stall_count <= o_stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/procyon_fifo_reader.md
PROCYON_FIFO_READER -- requirements
Module: procyon_fifo_reader

Interface
REQ-001 The block SHALL have parameter OPTN_DATA_WIDTH, default 8, meaning the data word width.
REQ-002 The block SHALL have parameter OPTN_SKID_DEPTH, default 2, meaning the number of skid-buffer entries (legal values 2..8, power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_flush, input, 1 bit: synchronous discard of all buffered and in-flight data.
REQ-006 The block SHALL have port o_fifo_ack, output, 1 bit: read request to the sync FIFO read port.
REQ-007 The block SHALL have port i_fifo_data, input, OPTN_DATA_WIDTH bits: FIFO read data, valid the cycle after an ack.
REQ-008 The block SHALL have port i_fifo_valid, input, 1 bit: FIFO has data available (registered non-empty).
REQ-009 The block SHALL have port o_data, output, OPTN_DATA_WIDTH bits: downstream data (skid-buffer head).
REQ-010 The block SHALL have port o_valid, output, 1 bit: downstream data valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: downstream accepts o_data this cycle when o_valid is high.

Function
REQ-012 The block SHALL define pop = o_valid & i_ready; a word transfers downstream only on pop.
REQ-013 The block SHALL assert o_fifo_ack = i_fifo_valid & ~i_flush & ((count + inflight - pop) < OPTN_SKID_DEPTH), so buffer overflow is never possible.
REQ-014 The block SHALL set its 1-bit inflight register to o_fifo_ack each cycle, and SHALL write i_fifo_data into the buffer tail in the cycle where inflight is 1 and i_flush is 0.
REQ-015 The block SHALL give an ack-to-o_valid latency of 2 cycles into an empty buffer: ack in cycle N, capture at the end of N+1, o_valid high in N+2.
REQ-016 The block SHALL sustain one word per cycle when i_fifo_valid and i_ready are held high.
REQ-017 The block SHALL keep count in 0..OPTN_SKID_DEPTH, with next count = count + capture - pop, where simultaneous capture and pop leaves count unchanged.
REQ-018 The block SHALL keep head and tail pointers $clog2(OPTN_SKID_DEPTH) bits wide, wrapping modulo the depth without a special case.
REQ-019 The block SHALL hold o_valid = (count != 0), and SHALL hold o_data stable while o_valid & ~i_ready.
REQ-020 On i_flush, the block SHALL force o_fifo_ack low in the same cycle, and at the next edge SHALL clear count, head, tail and inflight and drop any data arriving that cycle; o_valid SHALL be low the cycle after flush.
REQ-021 When i_flush and pop occur in the same cycle, the block SHALL give flush priority and leave the buffer empty.

Reset
REQ-022 Asynchronous assertion of n_rst SHALL immediately force o_fifo_ack=0, o_valid=0, count=0, head=0, tail=0 and inflight=0; o_data is don't-care while o_valid=0.
REQ-023 After n_rst deasserts, the block SHALL issue its first ack no earlier than the first rising edge with i_fifo_valid=1.
REQ-024 Reset asserted while a read is in flight SHALL discard that read without corrupting state after release.

Configuration
REQ-025 With macro PROCYON_FIFO_READER_PERF_EN defined, the block SHALL add output o_stall_count (16 bits, reset 0), incremented each cycle o_valid & ~i_ready, saturating at 16'hFFFF and cleared by i_flush.
REQ-026 Without PROCYON_FIFO_READER_PERF_EN, the port o_stall_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Streaming: i_fifo_valid=1 and i_ready=1 with data 0x01..0x10 -> 16 words out in order on consecutive cycles, first o_valid 2 cycles after first ack.
REQ-028 Backpressure: i_ready=0 for 5 cycles -> at most OPTN_SKID_DEPTH acks, o_data stable and no word lost or duplicated on release.
REQ-029 Wrap: 37 words with random i_ready (50%) and depth 2 -> output order matches input and count never exceeds 2.
REQ-030 Flush with inflight=1 and count=2 -> o_fifo_ack low in the flush cycle, o_valid=0 next cycle, and the in-flight word never appears.
REQ-031 Mid-stream reset: n_rst=0 asynchronously -> o_valid and o_fifo_ack low before the next edge; after release, streaming resumes cleanly.
REQ-032 PERF build: hold i_ready=0 with o_valid=1 for 70000 cycles -> o_stall_count=16'hFFFF, then 0 after i_flush.
